// File: rtl/touch_adc_spi_reader.sv
// SPI master for an AD7843-class touch ADC: on pen-down runs an X frame then a Y frame and publishes the pair.
// Optional 4-pair averaging is enabled with the TOUCH_ADC_AVG4_EN macro.
module touch_adc_spi_reader #(
  parameter int unsigned CLK_DIV    = 25,
  parameter logic [7:0]  CMD_X      = 8'hD0,
  parameter logic [7:0]  CMD_Y      = 8'h90,
  parameter int unsigned GAP_HALVES = 4
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        PENIRQ_n,
  input  logic        ADC_DOUT,
  output logic        ADC_CS_n,
  output logic        ADC_SCLK,
  output logic        ADC_DIN,
  output logic [11:0] X_COORD,
  output logic [11:0] Y_COORD,
  output logic        COORD_VALID,
  output logic        BUSY,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FRAME_X = 3'd1,
    ST_GAP_X   = 3'd2,
    ST_FRAME_Y = 3'd3,
    ST_GAP_Y   = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  div_q;
  logic [5:0]  half_q;
  logic [5:0]  half_d;
  logic        div_end;
  logic [7:0]  frame_cmd;
  logic [11:0] shift_q;
  logic [11:0] x_q;
  logic        pen_lost_q;
  logic        pen_meta_q;
  logic        pen_s_q;
  logic        cs_n_q;
  logic        sclk_q;
  logic        din_q;
  logic [11:0] x_coord_q;
  logic [11:0] y_coord_q;
  logic        valid_q;
  logic        busy_q;

`ifdef TOUCH_ADC_AVG4_EN
  logic [13:0] acc_x_q;
  logic [13:0] acc_y_q;
  logic [1:0]  pair_cnt_q;
  logic [13:0] sum_x_d;
  logic [13:0] sum_y_d;
  assign sum_x_d = acc_x_q + {2'b00, x_q};
  assign sum_y_d = acc_y_q + {2'b00, shift_q};
`endif

  assign half_d    = half_q + 6'd1;
  assign div_end   = (div_q == 8'(CLK_DIV - 1));
  assign frame_cmd = (state_q == ST_FRAME_X) ? CMD_X : CMD_Y;

  // Handshake: COORD_VALID is a single-cycle strobe with no back-pressure; X_COORD/Y_COORD are valid on it and hold afterwards.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      div_q      <= 8'd0;
      half_q     <= 6'd0;
      shift_q    <= 12'd0;
      x_q        <= 12'd0;
      pen_lost_q <= 1'b0;
      pen_meta_q <= 1'b1;
      pen_s_q    <= 1'b1;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      din_q      <= 1'b0;
      x_coord_q  <= 12'd0;
      y_coord_q  <= 12'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef TOUCH_ADC_AVG4_EN
      acc_x_q    <= 14'd0;
      acc_y_q    <= 14'd0;
      pair_cnt_q <= 2'd0;
`endif
    end else begin
      pen_meta_q <= PENIRQ_n;
      pen_s_q    <= pen_meta_q;
      valid_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pen_lost_q <= 1'b0;
          div_q      <= 8'd0;
          half_q     <= 6'd0;
          if (!pen_s_q) begin
            state_q <= ST_FRAME_X;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            din_q   <= CMD_X[7];
          end
`ifdef TOUCH_ADC_AVG4_EN
          else begin
            acc_x_q    <= 14'd0;
            acc_y_q    <= 14'd0;
            pair_cnt_q <= 2'd0;
          end
`endif
        end
        ST_FRAME_X, ST_FRAME_Y: begin
          if (!div_end) begin
            div_q <= div_q + 8'd1;
          end else begin
            div_q <= 8'd0;
            if (half_q == 6'd48) begin
              half_q <= 6'd0;
              cs_n_q <= 1'b1;
              sclk_q <= 1'b0;
              din_q  <= 1'b0;
              if (state_q == ST_FRAME_X) begin
                x_q     <= shift_q;
                state_q <= ST_GAP_X;
              end else begin
                state_q <= ST_GAP_Y;
`ifdef TOUCH_ADC_AVG4_EN
                if (!pen_lost_q) begin
                  if (pair_cnt_q == 2'd3) begin
                    x_coord_q  <= sum_x_d[13:2];
                    y_coord_q  <= sum_y_d[13:2];
                    valid_q    <= 1'b1;
                    acc_x_q    <= 14'd0;
                    acc_y_q    <= 14'd0;
                    pair_cnt_q <= 2'd0;
                  end else begin
                    acc_x_q    <= sum_x_d;
                    acc_y_q    <= sum_y_d;
                    pair_cnt_q <= pair_cnt_q + 2'd1;
                  end
                end
`else
                if (!pen_lost_q) begin
                  x_coord_q <= x_q;
                  y_coord_q <= shift_q;
                  valid_q   <= 1'b1;
                end
`endif
              end
            end else begin
              half_q <= half_d;
              // Odd halves are SCLK-high; rising edge n is half 2n-1, so data edges 10..21 are halves 19..41.
              if (half_d[0]) begin
                sclk_q <= 1'b1;
                if (pen_s_q) pen_lost_q <= 1'b1;
                if (half_d >= 6'd19 && half_d <= 6'd41) shift_q <= {shift_q[10:0], ADC_DOUT};
              end else begin
                sclk_q <= 1'b0;
                din_q  <= (half_d < 6'd16) ? frame_cmd[~half_d[3:1]] : 1'b0;
              end
            end
          end
        end
        ST_GAP_X, ST_GAP_Y: begin
          if (!div_end) begin
            div_q <= div_q + 8'd1;
          end else begin
            div_q <= 8'd0;
            if (half_q == 6'(GAP_HALVES - 1)) begin
              half_q <= 6'd0;
              if (state_q == ST_GAP_X) begin
                state_q <= ST_FRAME_Y;
                cs_n_q  <= 1'b0;
                din_q   <= CMD_Y[7];
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              half_q <= half_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ADC_CS_n    = cs_n_q;
  assign ADC_SCLK    = sclk_q;
  assign ADC_DIN     = din_q;
  assign X_COORD     = x_coord_q;
  assign Y_COORD     = y_coord_q;
  assign COORD_VALID = valid_q;
  assign BUSY        = busy_q;
  assign DBG_STATE   = state_q;

endmodule

// File: doc/touch_adc_spi_reader.md
Name: touch_adc_spi_reader

Overview:
- SPI master for the LTM touch-panel ADC (AD7843-class).
- On pen-down it runs one X conversion frame, then one Y conversion frame, and publishes a registered 12-bit X/Y pair with a one-cycle valid strobe.
- Its X_COORD/Y_COORD outputs feed the 7-segment coordinate display and the rest of the touch datapath.

Parameters:
- CLK_DIV, 25, system clocks per SCLK half-period; legal range 2..255 (50 MHz gives a 1 MHz SCLK).
- CMD_X, 8'hD0, control byte for an X measurement (12-bit, differential, power-down between conversions).
- CMD_Y, 8'h90, control byte for a Y measurement.
- GAP_HALVES, 4, SCLK half-periods that CS_n stays high between frames.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST_n  input  1  asynchronous active-low reset.
- PENIRQ_n  input  1  pen-down request from the ADC; active low; asynchronous to CLK.
- ADC_DOUT  input  1  serial data from the ADC.
- ADC_CS_n  output  1  chip select, active low.
- ADC_SCLK  output  1  serial clock; idles low.
- ADC_DIN  output  1  serial command to the ADC.
- X_COORD  output  12  last accepted X sample.
- Y_COORD  output  12  last accepted Y sample.
- COORD_VALID  output  1  one-cycle strobe; high on the cycle X_COORD/Y_COORD update.
- BUSY  output  1  high whenever not in IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - ADC_CS_n=1, ADC_SCLK=0, ADC_DIN=0.
  - X_COORD=0, Y_COORD=0, COORD_VALID=0, BUSY=0.
  - All counters cleared; FSM goes to IDLE.
- PENIRQ_n passes through a 2-flop synchronizer (pen_s); all decisions use pen_s.
- A half-period counter counts 0..CLK_DIV-1. Every phase below lasts exactly CLK_DIV clocks per half-period.
- FSM states: IDLE, FRAME_X, GAP_X, FRAME_Y, GAP_Y.
  - IDLE: when pen_s==0, go to FRAME_X. Clear pen_lost.
  - FRAME (X or Y):
    - ADC_CS_n falls on entry. ADC_DIN is driven with command bit 7 on the same cycle.
    - 24 SCLK pulses follow, each one low half then one high half.
    - At the start of low half k (k=1..24), ADC_DIN = cmd[8-k] for k<=8, otherwise 0.
    - ADC_DOUT is sampled on the CLK where SCLK goes 0->1.
    - Rising edges 10..21 capture D11..D0, MSB first. Edge 9 (busy) and edges 22..24 are ignored.
    - After the 24th high half, one trailing low half with CS_n still low, then CS_n rises.
    - Frame length is 49*CLK_DIV clocks from CS_n fall to CS_n rise.
  - GAP: CS_n high, SCLK low for GAP_HALVES*CLK_DIV clocks.
    - GAP_X then goes to FRAME_Y.
    - GAP_Y then goes to IDLE.
- Pen-lost rule: if pen_s==1 on any SCLK rising edge of either frame, set pen_lost. Both frames still run to completion; no abort.
- Publish: on the CLK where CS_n rises at the end of FRAME_Y:
  - if pen_lost==0, load X_COORD/Y_COORD and pulse COORD_VALID for exactly 1 cycle;
  - otherwise outputs hold and no strobe is issued.
- Repeat: back-to-back pairs while the pen stays down. IDLE lasts one cycle, then FRAME_X restarts.
- BUSY is 1 from the FRAME_X entry cycle through the last GAP_Y cycle.
- Coordinate outputs are registered and change only on a publish (or on reset).

Optional Feature:
- Macro: TOUCH_ADC_AVG4_EN.
- Defined:
  - X and Y each go through a 14-bit accumulator that sums 4 accepted pairs.
  - On the 4th accepted pair, X_COORD/Y_COORD = sum[13:2] (truncated), COORD_VALID pulses, and the accumulators clear.
  - A pen_lost pair is skipped and does not count toward the 4.
  - Returning to IDLE with pen_s==1 clears the accumulators and the pair count.
- Not defined: every accepted pair is published directly.

Test Plan:
- Reset: hold RST_n=0 mid-frame (CLK_DIV=2) -> CS_n=1, SCLK=0, DIN=0, COORD_VALID=0 on the same cycle; X_COORD=Y_COORD=0.
- Single pair (CLK_DIV=2): PENIRQ_n low; model returns 12'hA5C for X and 12'h3F1 for Y ->
  - DIN carries 8'hD0 then 8'h90, MSB first;
  - each frame is 98 clocks with CS_n low and exactly 24 SCLK pulses;
  - COORD_VALID is a 1-cycle pulse with X_COORD=12'hA5C, Y_COORD=12'h3F1.
- Continuous pen: PENIRQ_n held low for 3 pairs with values 0x001/0xFFE, 0x800/0x7FF, 0xFFF/0x000 -> three strobes with matching values; strobe spacing 2*(49+GAP_HALVES)*CLK_DIV+1 clocks.
- Pen release: PENIRQ_n goes high during FRAME_Y -> frame completes; no COORD_VALID; outputs keep the previous pair; FSM ends in IDLE with BUSY=0.
- Boundary values: DOUT all ones -> 12'hFFF; DOUT all zeros -> 12'h000. Busy-bit and trailing-bit values do not affect the result.
- TOUCH_ADC_AVG4_EN: X samples 100, 101, 102, 104 -> single strobe after the 4th pair with X_COORD=101 (407>>2); a pen_lost pair inserted mid-sequence delays the strobe by one pair.
